// File: rtl/pipe_adder_dut.sv
// Pipelined add/subtract unit: one operand stage feeding a DEPTH-entry result FIFO,
// gated by an INIT/RUN FSM. Define PIPE_ADDER_STATS_EN to add the txn_count output.
module pipe_adder_dut #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_data,
  output logic [1:0]       state
`ifdef PIPE_ADDER_STATS_EN
  ,
  output logic [15:0]      txn_count
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("pipe_adder_dut: WIDTH must be in 2..64");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pipe_adder_dut: DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic             stage_valid;
  logic [WIDTH:0]   stage_data;
  logic [WIDTH:0]   result;

  logic [WIDTH:0]   mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    occ;

  logic             in_fire;
  logic             push;
  logic             pop;

  // Zero-extended operands make the MSB the carry (add) or borrow (subtract).
  always_comb begin
    result = '0;
    if (in_sub) begin
      result = {1'b0, in_a} - {1'b0, in_b};
    end else begin
      result = {1'b0, in_a} + {1'b0, in_b};
    end
  end

  always_comb begin
    state_d   = state_q;
    occ       = count + CW'(stage_valid);
    in_ready  = 1'b0;
    out_valid = (count != '0);
    out_data  = '0;
    unique case (state_q)
      INIT: begin
        state_d = flush ? INIT : RUN;
      end
      RUN: begin
        in_ready = (occ < DEPTH_C);
        if (flush) begin
          state_d = INIT;
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase
    if (out_valid) begin
      out_data = mem[rptr];
    end
  end

  // flush overrides any handshake seen on the same edge.
  assign in_fire = in_valid && in_ready && !flush;
  assign pop     = out_valid && out_ready && !flush;
  assign push    = stage_valid && !flush;
  assign state   = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid <= 1'b0;
      stage_data  <= '0;
    end else begin
      stage_valid <= in_fire;
      if (in_fire) begin
        stage_data <= result;
      end
    end
  end

  // Storage carries no reset; out_data is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= stage_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef PIPE_ADDER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_count <= '0;
    end else if (flush) begin
      txn_count <= '0;
    end else if (pop && (txn_count != '1)) begin
      txn_count <= txn_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_adder_dut.sv
// Bench for pipe_adder_dut (WIDTH=8, DEPTH=4): randomized and directed traffic
// compared against a queue-based model of accepted-but-not-delivered results.
module tb_pipe_adder_dut;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   out_data;
  logic [1:0]   state;
`ifdef PIPE_ADDER_STATS_EN
  logic [15:0]  txn_count;
`endif

  always #5 clk = ~clk;

  pipe_adder_dut #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .state     (state)
`ifdef PIPE_ADDER_STATS_EN
    ,
    .txn_count (txn_count)
`endif
  );

  typedef struct {
    logic [W:0] d;
    int         acc;
  } item_t;

  item_t q[$];
  bit    run;
  int    edge_n;
  int    exp_txn;
  int    acc_seen;
  int    checks;
  int    passes;
  int    fails;

  function automatic logic [W:0] ref_res(input int a, input int b, input bit s);
    int r;
    r = s ? (a - b) : (a + b);
    return r[W:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                     input bit s, input bit ordy, input bit fl);
    bit ein;
    bit eov;
    ein = run && (q.size() < D);
    eov = (q.size() > 0) && (edge_n >= q[0].acc + 1);
    chk("in_ready", 32'(in_ready), 32'(ein));
    chk("out_valid", 32'(out_valid), 32'(eov));
    if (eov) chk("out_data", 32'(out_data), 32'(q[0].d));
    chk("state", 32'(state), 32'(run));
`ifdef PIPE_ADDER_STATS_EN
    chk("txn_count", 32'(txn_count), 32'(exp_txn));
`endif
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_sub    = s;
    out_ready = ordy;
    flush     = fl;
    if (v && in_ready && !fl) acc_seen++;
    @(posedge clk);
    edge_n++;
    if (fl) begin
      q.delete();
      run     = 1'b0;
      exp_txn = 0;
    end else if (!run) begin
      run = 1'b1;
    end else begin
      if (eov && ordy) begin
        void'(q.pop_front());
        if (exp_txn < 16'hFFFF) exp_txn++;
      end
      if (v && ein) q.push_back('{ref_res(int'(a), int'(b), s), edge_n});
    end
    #1;
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, ordy, 1'b0);
  endtask

  task automatic rnd(input bit v, input bit ordy);
    cyc(v, W'($urandom), W'($urandom), 1'($urandom), ordy, 1'b0);
  endtask

  initial begin
    checks = 0; passes = 0; fails = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_sub = 1'b0; out_ready = 1'b0;
    run = 1'b0; edge_n = 0; exp_txn = 0; acc_seen = 0;

    #2;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_state", 32'(state), 32'(0));
    #11;
    rst = 1'b0;

    // First edge after reset release: INIT -> RUN; in_ready follows.
    idle(2, 1'b1);

    // Add with carry out.
    cyc(1'b1, 8'd200, 8'd100, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b1);
    chk("add_200_100", 32'(out_data), 32'h12C);
    chk("add_valid_lat", 32'(out_valid), 32'(1));
    idle(1, 1'b1);

    // Subtract with and without borrow.
    cyc(1'b1, 8'd5, 8'd7, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 8'd7, 8'd5, 1'b1, 1'b1, 1'b0);
    chk("sub_5_7", 32'(out_data), 32'h1FE);
    idle(1, 1'b1);
    chk("sub_7_5", 32'(out_data), 32'h002);
    idle(1, 1'b1);

    // Backpressure: 6 offers with out_ready low, only DEPTH may be taken.
    acc_seen = 0;
    for (int i = 0; i < 6; i++) rnd(1'b1, 1'b0);
    chk("bp_accepted", 32'(acc_seen), 32'(4));
    chk("bp_in_ready_low", 32'(in_ready), 32'(0));
    idle(6, 1'b1);
    chk("bp_drained", 32'(out_valid), 32'(0));

    // Random valid/ready mix.
    for (int i = 0; i < 60; i++) rnd(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
    idle(6, 1'b1);

    // Continuous stream: one result per cycle once filled.
    acc_seen = 0;
    for (int i = 0; i < 24; i++) rnd(1'b1, 1'b1);
    chk("stream_accepts", 32'(acc_seen), 32'(24));
    idle(4, 1'b1);

    // Flush with three queued results, then a flush while in INIT.
    for (int i = 0; i < 3; i++) rnd(1'b1, 1'b0);
    idle(1, 1'b0);
    chk("pre_flush_valid", 32'(out_valid), 32'(1));
    cyc(1'b1, 8'd1, 8'd1, 1'b0, 1'b1, 1'b1);
    chk("flush_out_valid", 32'(out_valid), 32'(0));
    chk("flush_state", 32'(state), 32'(0));
    idle(2, 1'b1);
    chk("flush_in_ready", 32'(in_ready), 32'(1));
    for (int i = 0; i < 2; i++) rnd(1'b1, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Asynchronous reset between edges in the middle of a stream.
    for (int i = 0; i < 5; i++) rnd(1'b1, 1'($urandom_range(0, 1)));
    #3;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'(0));
    chk("arst_in_ready", 32'(in_ready), 32'(0));
    chk("arst_out_data", 32'(out_data), 32'(0));
    chk("arst_state", 32'(state), 32'(0));
`ifdef PIPE_ADDER_STATS_EN
    chk("arst_txn", 32'(txn_count), 32'(0));
`endif
    q.delete();
    run = 1'b0;
    exp_txn = 0;
    in_valid = 1'b0;
    @(posedge clk);
    edge_n++;
    #1;
    rst = 1'b0;
    idle(2, 1'b1);
    for (int i = 0; i < 20; i++) rnd(1'($urandom_range(0, 1)), 1'b1);
    idle(6, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
